multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/mc_pkg.sv | 56 +++++
 rtl/mc_decode.sv | 31 +++
 rtl/multicycle_ctrl.sv | 142 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multicycle controller.
//   state_e  : FSM state encoding (IF=0, ID=1, EX=2, MEM=3, WB=4)
//   cls_e    : decoded instruction class latched in ID
//   ALU_*/EXT_*/PC_* : Aluctrl, ExtOp and PCSrc select codes
//   OP_*/FN_*: OpCode and funct field values of the supported instructions
package mc_pkg;

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EX  = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4
   } state_e;

   typedef enum logic [3:0] {
      CLS_NONE = 4'd0,
      CLS_ADDU = 4'd1,
      CLS_SUBU = 4'd2,
      CLS_ORI  = 4'd3,
      CLS_LUI  = 4'd4,
      CLS_LW   = 4'd5,
      CLS_SW   = 4'd6,
      CLS_BEQ  = 4'd7,
      CLS_J    = 4'd8,
      CLS_ILL  = 4'd9
   } cls_e;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_OR  = 2'b10;
   localparam logic [1:0] ALU_LUI = 2'b11;

   localparam logic [1:0] EXT_ZERO  = 2'b00;
   localparam logic [1:0] EXT_SIGN  = 2'b01;
   localparam logic [1:0] EXT_UPPER = 2'b10;

   localparam logic [1:0] PC_SEQ = 2'b00;
   localparam logic [1:0] PC_BR  = 2'b01;
   localparam logic [1:0] PC_JMP = 2'b10;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUBU  = 6'b100011;

   function automatic logic is_rtype(cls_e c);
      return c == CLS_ADDU || c == CLS_SUBU;
   endfunction

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational OpCode/funct to instruction-class decoder.
//   OpCode : in  6 instruction opcode field
//   funct  : in  6 instruction function field (R-type only)
//   cls    : out 4 cls_e code; CLS_ILL for any unsupported pair
module mc_decode
   import mc_pkg::*;
(
   input  logic [5:0] OpCode,
   input  logic [5:0] funct,
   output logic [3:0] cls
);

   cls_e c;

   always_comb begin
      c = CLS_ILL;
      case (OpCode)
         OP_RTYPE: c = funct == FN_ADDU ? CLS_ADDU : funct == FN_SUBU ? CLS_SUBU : CLS_ILL;
         OP_ORI:   c = CLS_ORI;
         OP_LUI:   c = CLS_LUI;
         OP_LW:    c = CLS_LW;
         OP_SW:    c = CLS_SW;
         OP_BEQ:   c = CLS_BEQ;
         OP_J:     c = CLS_J;
         default:  c = CLS_ILL;
      endcase
   end

   assign cls = c;

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: five-state multicycle MIPS-subset control FSM with memory wait timeout.
//   clk, rst_n       : clock, synchronous active-low reset
//   OpCode, funct    : instruction fields from the instruction register
//   zero             : ALU zero flag (beq)
//   mem_ready        : memory access-complete handshake
//   PCWr..Alusrc     : datapath enables/selects
//   ExtOp, Aluctrl, PCSrc : 2-bit datapath selects
//   illegal, timeout : one-cycle event pulses
//   state            : current FSM state
module multicycle_ctrl
   import mc_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] OpCode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       PCWr,
   output logic       IRWr,
   output logic       MemR,
   output logic       MemW,
   output logic       RegW,
   output logic       RegDst,
   output logic       Mem2R,
   output logic       Alusrc,
   output logic [1:0] ExtOp,
   output logic [1:0] Aluctrl,
   output logic [1:0] PCSrc,
   output logic       illegal,
   output logic       timeout,
   output logic [2:0] state
);

   localparam logic [3:0] TO_CNT = 4'(MEM_TIMEOUT);

   state_e     st, st_n;
   cls_e       cls_q, cls_d, cls;
   logic [3:0] cnt, cnt_n;
   logic [3:0] cls_raw;
   logic       to_hit;

   mc_decode u_decode (
      .OpCode (OpCode),
      .funct  (funct),
      .cls    (cls_raw)
   );

   assign cls_d = cls_e'(cls_raw);
   // In ID the register is not yet loaded, so the live decode drives the routing.
   assign cls = st == S_ID ? cls_d : cls_q;
   assign to_hit = (st == S_IF || st == S_MEM) && cnt == TO_CNT && !mem_ready;
   assign state = st;

   always_comb begin
      st_n    = st;
      PCWr    = 1'b0;
      IRWr    = 1'b0;
      MemR    = 1'b0;
      MemW    = 1'b0;
      RegW    = 1'b0;
      RegDst  = 1'b0;
      Mem2R   = 1'b0;
      Alusrc  = 1'b0;
      ExtOp   = EXT_ZERO;
      Aluctrl = ALU_ADD;
      PCSrc   = PC_SEQ;
      illegal = 1'b0;
      timeout = 1'b0;
      case (st)
         S_IF: begin
            MemR = 1'b1;
            if (mem_ready) begin
               IRWr = 1'b1;
               PCWr = 1'b1;
               st_n = S_ID;
            end else if (to_hit) begin
               timeout = 1'b1;
               st_n    = S_IF;
            end
         end
         S_ID: begin
            if (cls == CLS_J) begin
               PCWr  = 1'b1;
               PCSrc = PC_JMP;
               st_n  = S_IF;
            end else if (cls == CLS_ILL) begin
               illegal = 1'b1;
               st_n    = S_IF;
            end else begin
               st_n = S_EX;
            end
         end
         S_EX: begin
            Alusrc  = cls == CLS_ORI || cls == CLS_LUI || cls == CLS_LW || cls == CLS_SW;
            ExtOp   = cls == CLS_LUI ? EXT_UPPER : (cls == CLS_LW || cls == CLS_SW) ? EXT_SIGN : EXT_ZERO;
            Aluctrl = cls == CLS_ORI ? ALU_OR : cls == CLS_LUI ? ALU_LUI :
                      (cls == CLS_SUBU || cls == CLS_BEQ) ? ALU_SUB : ALU_ADD;
            PCWr    = cls == CLS_BEQ && zero;
            PCSrc   = cls == CLS_BEQ ? PC_BR : PC_SEQ;
            st_n    = cls == CLS_BEQ ? S_IF : (cls == CLS_LW || cls == CLS_SW) ? S_MEM : S_WB;
         end
         S_MEM: begin
            MemR = cls == CLS_LW;
            // The write strobe is withdrawn in the abandon cycle so no partial store lands.
            MemW = cls == CLS_SW && !to_hit;
            if (mem_ready) begin
               st_n = cls == CLS_LW ? S_WB : S_IF;
            end else if (to_hit) begin
               timeout = 1'b1;
               st_n    = S_IF;
            end
         end
         S_WB: begin
            RegW   = 1'b1;
            RegDst = is_rtype(cls);
            Mem2R  = cls == CLS_LW;
            st_n   = S_IF;
         end
         default: st_n = S_IF;
      endcase
   end

   // Only IF/MEM waits self-loop; any transition (including a timeout re-entry of IF) clears.
   assign cnt_n = (st_n == st && !timeout) ? cnt + 4'd1 : 4'd0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st    <= S_IF;
         cnt   <= 4'd0;
         cls_q <= CLS_NONE;
      end else begin
         st    <= st_n;
         cnt   <= cnt_n;
         if (st == S_ID)
            cls_q <= cls_d;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized instruction stream checked against a per-instruction behavioural model.
module tb_multicycle_ctrl;

   localparam int TO = 15;
   localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4, K_SW = 5, K_BEQ = 6, K_J = 7, K_ILL = 8;

   typedef struct packed {
      logic [2:0] st;
      logic pcwr, irwr, memr, memw, regw, regdst, mem2r, alusrc;
      logic [1:0] extop, aluctrl, pcsrc;
      logic ill, to;
   } ov_t;

   logic clk = 1'b0, rst_n = 1'b0;
   logic [5:0] OpCode = '0, funct = '0;
   logic zero = 1'b0, mem_ready = 1'b0;
   logic PCWr, IRWr, MemR, MemW, RegW, RegDst, Mem2R, Alusrc, illegal, timeout;
   logic [1:0] ExtOp, Aluctrl, PCSrc;
   logic [2:0] state;

   multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .PCWr(PCWr), .IRWr(IRWr), .MemR(MemR), .MemW(MemW), .RegW(RegW), .RegDst(RegDst), .Mem2R(Mem2R),
      .Alusrc(Alusrc), .ExtOp(ExtOp), .Aluctrl(Aluctrl), .PCSrc(PCSrc), .illegal(illegal),
      .timeout(timeout), .state(state)
   );

   always #5 clk = ~clk;

   ov_t q[$];
   ov_t ce, ca;
   int vectors = 0, errs = 0;
   int memw_n = 0, to_n = 0;

   always @(negedge clk) begin
      if (MemW) memw_n++;
      if (timeout) to_n++;
      if (q.size() > 0) begin
         ce = q.pop_front();
         ca = {state, PCWr, IRWr, MemR, MemW, RegW, RegDst, Mem2R, Alusrc, ExtOp, Aluctrl, PCSrc, illegal, timeout};
         vectors++;
         if (ca !== ce) begin
            errs++;
            $display("FAIL outputs t=%0t got=%b required=%b", $time, ca, ce);
         end
      end
   end

   task automatic chk(input string n, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s got=%0d required=%0d", n, act, exp);
      end
   endtask

   task automatic cyc(input ov_t e);
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   function automatic ov_t base(input int s);
      ov_t e = '0;
      e.st = 3'(s);
      return e;
   endfunction

   function automatic int kind(input logic [5:0] op, input logic [5:0] fn);
      case (op)
         6'b000000: return fn == 6'b100001 ? K_ADDU : fn == 6'b100011 ? K_SUBU : K_ILL;
         6'b001101: return K_ORI;
         6'b001111: return K_LUI;
         6'b100011: return K_LW;
         6'b101011: return K_SW;
         6'b000100: return K_BEQ;
         6'b000010: return K_J;
         default:   return K_ILL;
      endcase
   endfunction

   // What the execute cycle must drive for each instruction.
   function automatic ov_t ex_vec(input int k, input logic z);
      ov_t e = base(2);
      case (k)
         K_SUBU: e.aluctrl = 2'b01;
         K_ORI:  begin e.alusrc = 1; e.extop = 2'b00; e.aluctrl = 2'b10; end
         K_LUI:  begin e.alusrc = 1; e.extop = 2'b10; e.aluctrl = 2'b11; end
         K_LW, K_SW: begin e.alusrc = 1; e.extop = 2'b01; end
         K_BEQ:  begin e.aluctrl = 2'b01; e.pcwr = z; e.pcsrc = 2'b01; end
         default: ;
      endcase
      return e;
   endfunction

   task automatic noise();
      OpCode = 6'($urandom);
      funct = 6'($urandom);
      zero = 1'($urandom);
   endtask

   // A memory wait of w cycles: ready arrives on wait cycle w unless that is past the limit.
   task automatic wait_phase(input int s, input int k, input int w, output bit ok);
      ov_t e;
      for (int i = 0; i <= w && i <= TO; i++) begin
         noise();
         mem_ready = (i == w);
         e = base(s);
         e.to = (i == TO) && (i != w);
         if (s == 0) begin
            e.memr = 1;
            e.irwr = (i == w);
            e.pcwr = (i == w);
         end else begin
            e.memr = (k == K_LW);
            e.memw = (k == K_SW) && !e.to;
         end
         cyc(e);
      end
      ok = (w <= TO);
   endtask

   task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z, input int fw, input int mw);
      ov_t e;
      bit ok;
      int k = kind(op, fn);
      wait_phase(0, k, fw, ok);
      if (!ok) return;
      OpCode = op;
      funct = fn;
      mem_ready = 1'($urandom);
      zero = 1'($urandom);
      e = base(1);
      if (k == K_J) begin e.pcwr = 1; e.pcsrc = 2'b10; end
      if (k == K_ILL) e.ill = 1;
      cyc(e);
      if (k == K_J || k == K_ILL) return;
      noise();
      zero = z;
      mem_ready = 1'($urandom);
      cyc(ex_vec(k, z));
      if (k == K_BEQ) return;
      if (k == K_LW || k == K_SW) begin
         wait_phase(3, k, mw, ok);
         if (!ok || k == K_SW) return;
      end
      noise();
      mem_ready = 1'($urandom);
      e = base(4);
      e.regw = 1;
      e.regdst = (k == K_ADDU || k == K_SUBU);
      e.mem2r = (k == K_LW);
      cyc(e);
   endtask

   task automatic measure(input string nm, input logic [5:0] op, input logic [5:0] fn, input int exp_n);
      int n = 0;
      OpCode = op;
      funct = fn;
      zero = 1;
      mem_ready = 1;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (state != 0 && n < 20);
      chk(nm, n, exp_n);
   endtask

   function automatic int rand_wait();
      int r = $urandom_range(0, 9);
      return r < 7 ? $urandom_range(0, 3) : $urandom_range(13, 18);
   endfunction

   logic [5:0] ops[8] = '{6'b000000, 6'b000000, 6'b001101, 6'b001111, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
   logic [5:0] fns[8] = '{6'b100001, 6'b100011, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0};

   initial begin
      ov_t e;
      bit ok;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", int'(state), 0);
      chk("rst_memr", int'(MemR), 1);
      chk("rst_others", int'({PCWr, IRWr, MemW, RegW, RegDst, Mem2R, Alusrc, ExtOp, Aluctrl, PCSrc, illegal, timeout}), 0);
      e = base(0);
      e.memr = 1;
      cyc(e);
      rst_n = 1;
      // Directed instruction lengths with an immediately ready memory.
      measure("len_j", 6'b000010, 6'b0, 2);
      measure("len_beq", 6'b000100, 6'b0, 3);
      measure("len_addu", 6'b000000, 6'b100001, 4);
      measure("len_ori", 6'b001101, 6'b0, 4);
      measure("len_sw", 6'b101011, 6'b0, 4);
      measure("len_lw", 6'b100011, 6'b0, 5);
      measure("len_illegal", 6'b111111, 6'b0, 2);
      run(6'b100011, 6'b0, 0, 0, 0);
      run(6'b000100, 6'b0, 1, 0, 0);
      run(6'b000100, 6'b0, 0, 0, 0);
      run(6'b111111, 6'b0, 0, 0, 0);
      run(6'b000000, 6'b100000, 0, 1, 0);
      // Store abandoned after the full wait, then one completing on the last wait cycle.
      memw_n = 0; to_n = 0;
      run(6'b101011, 6'b0, 0, 0, 40);
      run(6'b000000, 6'b100011, 0, 0, 0);
      chk("sw_to_memw_cycles", memw_n, 15);
      chk("sw_to_pulses", to_n, 1);
      memw_n = 0; to_n = 0;
      run(6'b101011, 6'b0, 0, 0, 15);
      chk("sw_late_memw_cycles", memw_n, 16);
      chk("sw_late_pulses", to_n, 0);
      to_n = 0;
      run(6'b001111, 6'b0, 0, 30, 0);
      chk("if_to_pulses", to_n, 1);
      // Reset while a load is waiting in MEM.
      wait_phase(0, K_LW, 0, ok);
      OpCode = 6'b100011; funct = 6'b0; mem_ready = 0;
      cyc(base(1));
      noise();
      cyc(ex_vec(K_LW, 0));
      e = base(3);
      e.memr = 1;
      cyc(e);
      rst_n = 0;
      cyc(e);
      chk("mem_rst_state", int'(state), 0);
      chk("mem_rst_others", int'({PCWr, IRWr, MemW, RegW, RegDst, Mem2R, Alusrc, ExtOp, Aluctrl, PCSrc, illegal, timeout}), 0);
      e = base(0);
      e.memr = 1;
      cyc(e);
      rst_n = 1;
      for (int i = 0; i < 300; i++) begin
         int s = $urandom_range(0, 9);
         if (s < 8) run(ops[s], fns[s], 1'($urandom), rand_wait(), rand_wait());
         else run(6'($urandom), 6'($urandom), 1'($urandom), rand_wait(), rand_wait());
      end
      @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
